// File: rtl/change_dispenser.sv
// Greedy 50/10/5/1 change payout with per-denomination inventory; first coin 2 cycles after start, then >=2 cycles per coin.
// Backpressure: coin_valid/coin_code hold until coin_ack; start/refill are ignored while busy.
module change_dispenser #(
    parameter int unsigned INIT_COUNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] charge,
    input  logic       refill,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_code,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remaining,
    output logic [3:0] inv_empty
);

    localparam logic [7:0] INIT = 8'(INIT_COUNT);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

    state_t     state, state_nx;
    logic [7:0] inv    [4];
    logic [7:0] inv_nx [4];
    logic       coin_valid_nx, busy_nx, done_nx, short_nx;
    logic [1:0] coin_code_nx;
    logic [7:0] remaining_nx;
    logic [1:0] pick;
    logic       found;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    coin_value = 8'd50;
            2'd1:    coin_value = 8'd10;
            2'd2:    coin_value = 8'd5;
            default: coin_value = 8'd1;
        endcase
    endfunction

    // Scan smallest to largest so the largest payable denomination wins.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (coin_value(2'(i)) <= remaining && inv[i] != 8'd0) begin
                pick  = 2'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        coin_valid_nx = coin_valid;
        coin_code_nx  = coin_code;
        short_nx      = short;
        remaining_nx  = remaining;
        for (int i = 0; i < 4; i++) begin
            inv_nx[i] = inv[i];
        end

        case (state)
            IDLE: begin
                if (refill) begin
                    for (int i = 0; i < 4; i++) begin
                        inv_nx[i] = INIT;
                    end
                end
                if (start) begin
                    remaining_nx = charge;
                    short_nx     = 1'b0;
                    state_nx     = SELECT;
                end
            end
            SELECT: begin
                if (remaining == 8'd0) begin
                    short_nx = 1'b0;
                    state_nx = FINISH;
                end else if (found) begin
                    coin_code_nx  = pick;
                    coin_valid_nx = 1'b1;
                    state_nx      = ISSUE;
                end else begin
                    short_nx = 1'b1;
                    state_nx = FINISH;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    remaining_nx      = remaining - coin_value(coin_code);
                    inv_nx[coin_code] = inv[coin_code] - 8'd1;
                    coin_valid_nx     = 1'b0;
                    state_nx          = SELECT;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            coin_valid <= 1'b0;
            coin_code  <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            remaining  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                inv[i] <= INIT;
            end
        end else begin
            state      <= state_nx;
            coin_valid <= coin_valid_nx;
            coin_code  <= coin_code_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            short      <= short_nx;
            remaining  <= remaining_nx;
            for (int i = 0; i < 4; i++) begin
                inv[i] <= inv_nx[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv_empty[i] = (inv[i] == 8'd0);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Two dispensers (INIT_COUNT 8 and 2) share stimulus; a greedy reference model feeds per-DUT scoreboards.
module tb_change_dispenser;

    localparam int INIT_A = 8;
    localparam int INIT_B = 2;

    logic       clk = 1'b0;
    logic       rst, start, refill, coin_ack;
    logic [7:0] charge;
    logic [1:0] cv, busy, done, shrt;
    logic [1:0] cc   [2];
    logic [7:0] rem  [2];
    logic [3:0] iemp [2];

    always #5 clk = ~clk;

    change_dispenser #(.INIT_COUNT(INIT_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .charge(charge), .refill(refill),
        .coin_ack(coin_ack), .coin_valid(cv[0]), .coin_code(cc[0]), .busy(busy[0]),
        .done(done[0]), .short(shrt[0]), .remaining(rem[0]), .inv_empty(iemp[0])
    );

    change_dispenser #(.INIT_COUNT(INIT_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .charge(charge), .refill(refill),
        .coin_ack(coin_ack), .coin_valid(cv[1]), .coin_code(cc[1]), .busy(busy[1]),
        .done(done[1]), .short(shrt[1]), .remaining(rem[1]), .inv_empty(iemp[1])
    );

    typedef struct packed {
        logic [7:0] rem;
        logic       shrt;
        logic [3:0] emp;
    } res_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         ack_mode = 0;
    int         inv_m [2][4];
    logic [1:0] exp_c0 [$];
    logic [1:0] exp_c1 [$];
    res_t       res_q0 [$];
    res_t       res_q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dval(input int d);
        case (d)
            0:       dval = 50;
            1:       dval = 10;
            2:       dval = 5;
            default: dval = 1;
        endcase
    endfunction

    task automatic model_refill(input int k);
        for (int d = 0; d < 4; d++) inv_m[k][d] = (k == 0) ? INIT_A : INIT_B;
    endtask

    task automatic reset_model();
        model_refill(0);
        model_refill(1);
        exp_c0.delete();
        exp_c1.delete();
        res_q0.delete();
        res_q1.delete();
    endtask

    // Greedy by whole denominations: take as many of each as the balance and stock allow.
    task automatic model_payout(input int k, input int c);
        int   r;
        int   n;
        res_t res;
        r = c;
        for (int d = 0; d < 4; d++) begin
            n = r / dval(d);
            if (n > inv_m[k][d]) n = inv_m[k][d];
            repeat (n) begin
                if (k == 0) exp_c0.push_back(2'(d));
                else        exp_c1.push_back(2'(d));
            end
            inv_m[k][d] -= n;
            r -= n * dval(d);
        end
        res.rem  = 8'(r);
        res.shrt = (r != 0);
        for (int d = 0; d < 4; d++) res.emp[d] = (inv_m[k][d] == 0);
        if (k == 0) res_q0.push_back(res);
        else        res_q1.push_back(res);
    endtask

    task automatic do_start(input int c, input bit rf);
        for (int k = 0; k < 2; k++) begin
            if (rf) model_refill(k);
            model_payout(k, c);
        end
        start  = 1'b1;
        charge = 8'(c);
        refill = rf;
        @(posedge clk); #1;
        start  = 1'b0;
        refill = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 2'b00 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done_low"}, done, 0);
        chk({name, "_coins_left"}, exp_c0.size() + exp_c1.size(), 0);
        chk({name, "_results_left"}, res_q0.size() + res_q1.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (cv !== 2'b11 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_valid"}, cv, 2'b11);
    endtask

    task automatic mon(input int k);
        logic [1:0] e;
        res_t       r;
        if (cv[k] === 1'b1 && coin_ack === 1'b1) begin
            if ((k == 0 ? exp_c0.size() : exp_c1.size()) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_coin dut%0d: got code %0d expected no coin", k, cc[k]);
            end else begin
                e = (k == 0) ? exp_c0.pop_front() : exp_c1.pop_front();
                chk($sformatf("coin_code_dut%0d", k), cc[k], e);
            end
        end
        if (done[k] === 1'b1) begin
            if ((k == 0 ? res_q0.size() : res_q1.size()) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done dut%0d: got done=1 expected done=0", k);
            end else begin
                r = (k == 0) ? res_q0.pop_front() : res_q1.pop_front();
                chk($sformatf("remaining_dut%0d", k), rem[k], r.rem);
                chk($sformatf("short_dut%0d", k), shrt[k], r.shrt);
                chk($sformatf("inv_empty_dut%0d", k), iemp[k], r.emp);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                mon(0);
                mon(1);
            end
        end
    end

    initial begin
        coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       coin_ack = 1'b0;
                1:       coin_ack = 1'b1;
                2:       coin_ack = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c0, c1;
        rst = 1'b1; start = 1'b0; refill = 1'b0; charge = 8'd0;
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), cv[k], 0);
            chk($sformatf("rst_code%0d", k), cc[k], 0);
            chk($sformatf("rst_busy%0d", k), busy[k], 0);
            chk($sformatf("rst_done%0d", k), done[k], 0);
            chk($sformatf("rst_short%0d", k), shrt[k], 0);
            chk($sformatf("rst_rem%0d", k), rem[k], 0);
            chk($sformatf("rst_empty%0d", k), iemp[k], 0);
        end
        @(posedge clk); #1;

        // zero charge: done in the second cycle after the start edge
        ack_mode = 1;
        do_start(0, 1'b0);
        chk("zero_busy", busy, 2'b11);
        @(posedge clk); #1;
        chk("zero_done", done, 2'b11);
        chk("zero_valid", cv, 0);
        wait_idle("zero");

        // exhaustion on the small-stock dispenser
        do_start(120, 1'b0);
        wait_idle("ex120");
        chk("ex120_empty_b", iemp[1], 4'b0011);
        do_start(30, 1'b0);
        wait_idle("ex30");
        chk("ex30_short_b", shrt[1], 1);
        chk("ex30_rem_b", rem[1], 18);
        chk("ex30_empty_b", iemp[1], 4'b1111);

        // start and refill while busy are ignored
        do_start(40, 1'b0);
        start = 1'b1; charge = 8'd5; refill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; refill = 1'b0;
        wait_idle("busyctl");
        chk("busyctl_empty_b", iemp[1], 4'b1111);

        // refill in idle
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        model_refill(0);
        model_refill(1);
        chk("refill_empty_a", iemp[0], 0);
        chk("refill_empty_b", iemp[1], 0);

        // ack while idle, then a stalled coin
        ack_mode = 3;
        coin_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 coin_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        do_start(60, 1'b0);
        wait_valid("stall");
        c0 = cc[0]; c1 = cc[1];
        chk("stall_first_code", cc[0], 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_valid", cv, 2'b11);
            chk("stall_code_a", cc[0], c0);
            chk("stall_code_b", cc[1], c1);
            chk("stall_rem", rem[0], 60);
        end
        coin_ack = 1'b1;
        @(posedge clk); #1;
        chk("acked_valid", cv, 0);
        chk("acked_rem", rem[0], 10);
        @(posedge clk); #1;
        chk("invalid_ack_rem", rem[0], 10);
        chk("next_coin_valid", cv, 2'b11);
        coin_ack = 1'b0;
        ack_mode = 2;
        wait_idle("stall");

        // refill and start together
        ack_mode = 1;
        do_start(10, 1'b1);
        wait_idle("rfstart");
        do_start(87, 1'b1);
        wait_idle("p87");
        chk("p87_rem_a", rem[0], 0);
        chk("p87_short_a", shrt[0], 0);

        // random payouts with random ack timing
        ack_mode = 2;
        for (int i = 0; i < 40; i++) begin
            do_start(int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            wait_idle("rand");
        end

        // reset in the middle of a payout
        ack_mode = 0;
        do_start(200, 1'b1);
        wait_valid("midrst");
        #2 rst = 1'b1;
        #1;
        reset_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_valid%0d", k), cv[k], 0);
            chk($sformatf("midrst_busy%0d", k), busy[k], 0);
            chk($sformatf("midrst_rem%0d", k), rem[k], 0);
            chk($sformatf("midrst_code%0d", k), cc[k], 0);
            chk($sformatf("midrst_empty%0d", k), iemp[k], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        ack_mode = 1;
        @(posedge clk); #1;
        do_start(50, 1'b0);
        wait_idle("post_rst");
        chk("post_rst_rem", rem[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
